// File: rtl/vga_pkg.sv
// Raster constants shared with the VGA timing generator, plus the
// memory-port scheduler state encoding.
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_GAP    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/vga_frame_scheduler_rr_arbiter.sv
// Combinational one-hot round-robin picker; the search starts one past the
// previous owner and wraps modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index,
  output logic             valid
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last_owner) + i) % N_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Shares the video-memory port between per-line prefetches (horizontal
// blanking) and round-robin update requesters (vertical blanking only).
module vga_frame_scheduler
  import vga_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic               fetch_req,
  output logic [8:0]         fetch_line,
  input  logic               fetch_done,
  input  logic [N_REQ-1:0]   upd_req,
  output logic [N_REQ-1:0]   upd_gnt,
  output logic               frame_start,
  output logic               vblank,
  output logic               overrun,
  output logic [ERR_W-1:0]   err_count,
  output sched_state_t       state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [9:0] X_TRIG     = 10'(H_DISPLAY);
  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST_VIS = 10'(V_DISPLAY - 1);
  localparam logic [9:0] Y_WIN_LO   = 10'(V_DISPLAY);
  localparam logic [9:0] Y_WIN_HI   = 10'(V_TOTAL - 2);
  localparam logic [9:0] Y_PRE0     = 10'(V_TOTAL - 1);

  sched_state_t     state_n;
  logic             fetch_req_n;
  logic [8:0]       fetch_line_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IW-1:0]    owner, owner_n;
  logic [IW-1:0]    last_owner, last_owner_n;
  logic             overrun_n;
  logic [ERR_W-1:0] err_n;

  logic             fetch_trig, window, deadline, last_slot;
  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_index;
  logic             arb_valid;

  // Line 524 prefetches line 0, so it is excluded from the update window.
  assign fetch_trig = (x == X_TRIG) && ((y < Y_LAST_VIS) || (y == Y_PRE0));
  assign window     = (y >= Y_WIN_LO) && (y <= Y_WIN_HI);
  assign deadline   = (x == X_LAST);
  assign last_slot  = deadline && (y == Y_WIN_HI);

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req        (upd_req),
    .last_owner (last_owner),
    .grant      (arb_grant),
    .index      (arb_index),
    .valid      (arb_valid)
  );

  always_comb begin
    state_n      = state;
    fetch_req_n  = fetch_req;
    fetch_line_n = fetch_line;
    gnt_n        = upd_gnt;
    owner_n      = owner;
    last_owner_n = last_owner;
    overrun_n    = 1'b0;
    err_n        = err_count;
    case (state)
      ST_IDLE: begin
        if (fetch_trig) begin
          state_n      = ST_FETCH;
          fetch_req_n  = 1'b1;
          fetch_line_n = (y == Y_PRE0) ? 9'd0 : 9'(y + 10'd1);
        end else if (window && !last_slot && arb_valid) begin
          // No new grant in the final slot: it would spill into line 524.
          state_n      = ST_UPDATE;
          gnt_n        = arb_grant;
          owner_n      = arb_index;
          last_owner_n = arb_index;
        end
      end
      ST_FETCH: begin
        if (fetch_done) begin
          state_n     = ST_IDLE;
          fetch_req_n = 1'b0;
        end else if (deadline) begin
          overrun_n = 1'b1;
          if (err_count != '1) err_n = err_count + 1'b1;
        end
      end
      ST_UPDATE: begin
        if (!upd_req[owner] || last_slot) begin
          state_n = ST_GAP;
          gnt_n   = '0;
        end
      end
      ST_GAP:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      fetch_req   <= 1'b0;
      fetch_line  <= '0;
      upd_gnt     <= '0;
      owner       <= '0;
      last_owner  <= IW'(N_REQ - 1);
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      overrun     <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      fetch_req   <= fetch_req_n;
      fetch_line  <= fetch_line_n;
      upd_gnt     <= gnt_n;
      owner       <= owner_n;
      last_owner  <= last_owner_n;
      frame_start <= (x == 10'd0) && (y == 10'd0);
      vblank      <= window;
      overrun     <= overrun_n;
      err_count   <= err_n;
    end
  end

endmodule
